stopwatch_core: RTL and testbench

- Consumes the single-cycle press pulses from the button debounce stage.
- Owns the stopwatch run/stop/clear control FSM and the time-keeping datapath: 100 Hz tick divider and cascaded centisecond/second/minute/hour counters.
- Outputs feed the FND display formatter downstream.

---
 rtl/stopwatch_core.sv | 127 ++++++++++++
 tb/tb_stopwatch_core.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_core.sv
// Stopwatch control FSM and time-keeping datapath: centisecond tick divider feeding
// cascaded msec/sec/min/hour counters. All outputs come straight from registers.
module stopwatch_core #(
    parameter int unsigned TICK_DIV = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_btn_run,
    input  logic       i_btn_clear,
    output logic [6:0] o_msec,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic [4:0] o_hour,
    output logic       o_running
);

    localparam int unsigned DivW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DivW-1:0] DivMax = DivW'(TICK_DIV - 1);

    typedef enum logic [1:0] {StStop, StRun, StClear} state_e;

    state_e            state_q;
    logic              running_q;
    logic [DivW-1:0]   div_q, div_d;
    logic [6:0]        msec_q, msec_d;
    logic [5:0]        sec_q, sec_d;
    logic [5:0]        min_q, min_d;
    logic [4:0]        hour_q, hour_d;
    logic              tick;
    logic              clear_enter;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StStop;
            running_q <= 1'b0;
        end else begin
            case (state_q)
                StStop: begin
                    // Run has priority over a coincident clear.
                    if (i_btn_run) begin
                        state_q   <= StRun;
                        running_q <= 1'b1;
                    end else if (i_btn_clear) begin
                        state_q <= StClear;
                    end
                end
                StRun: begin
                    if (i_btn_run) begin
                        state_q   <= StStop;
                        running_q <= 1'b0;
                    end
                end
                StClear: state_q <= StStop;
                default: begin
                    state_q   <= StStop;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign tick        = (state_q == StRun) && (div_q == DivMax);
    assign clear_enter = (state_q == StStop) && i_btn_clear && !i_btn_run;

    // Divider holds in STOP so the sub-tick phase survives a pause.
    always_comb begin
        div_d = div_q;
        if (state_q == StRun) begin
            div_d = tick ? '0 : div_q + DivW'(1);
        end else if (clear_enter || state_q == StClear) begin
            div_d = '0;
        end
    end

    always_comb begin
        msec_d = msec_q;
        sec_d  = sec_q;
        min_d  = min_q;
        hour_d = hour_q;
        if (state_q == StClear) begin
            msec_d = '0;
            sec_d  = '0;
            min_d  = '0;
            hour_d = '0;
        end else if (tick) begin
            if (msec_q == 7'd99) begin
                msec_d = '0;
                if (sec_q == 6'd59) begin
                    sec_d = '0;
                    if (min_q == 6'd59) begin
                        min_d  = '0;
                        hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
                    end else begin
                        min_d = min_q + 6'd1;
                    end
                end else begin
                    sec_d = sec_q + 6'd1;
                end
            end else begin
                msec_d = msec_q + 7'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q  <= '0;
            msec_q <= '0;
            sec_q  <= '0;
            min_q  <= '0;
            hour_q <= '0;
        end else begin
            div_q  <= div_d;
            msec_q <= msec_d;
            sec_q  <= sec_d;
            min_q  <= min_d;
            hour_q <= hour_d;
        end
    end

    assign o_msec    = msec_q;
    assign o_sec     = sec_q;
    assign o_min     = min_q;
    assign o_hour    = hour_q;
    assign o_running = running_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Scoreboard bench for stopwatch_core: stimulus queues hand-computed expected readings,
// a monitor process pops and compares them against the DUT outputs.
module tb_stopwatch_core;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_btn_run = 1'b0;
    logic       i_btn_clear = 1'b0;
    logic [6:0] o_msec;
    logic [5:0] o_sec;
    logic [5:0] o_min;
    logic [4:0] o_hour;
    logic       o_running;

    typedef struct {
        string      name;
        logic [6:0] msec;
        logic [5:0] sec;
        logic [5:0] min;
        logic [4:0] hour;
        logic       run;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    stopwatch_core #(.TICK_DIV(10)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_btn_run   (i_btn_run),
        .i_btn_clear (i_btn_clear),
        .o_msec      (o_msec),
        .o_sec       (o_sec),
        .o_min       (o_min),
        .o_hour      (o_hour),
        .o_running   (o_running)
    );

    always #5 clk = ~clk;

    task automatic expect_now(input string name, input int h, input int m, input int s,
                              input int cs, input logic run);
        exp_t e;
        e.name = name;
        e.hour = 5'(h);
        e.min  = 6'(m);
        e.sec  = 6'(s);
        e.msec = 7'(cs);
        e.run  = run;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_run();
        i_btn_run = 1'b1;
        @(negedge clk);
        i_btn_run = 1'b0;
    endtask

    task automatic pulse_clear();
        i_btn_clear = 1'b1;
        @(negedge clk);
        i_btn_clear = 1'b0;
    endtask

    task automatic pulse_both();
        i_btn_run   = 1'b1;
        i_btn_clear = 1'b1;
        @(negedge clk);
        i_btn_run   = 1'b0;
        i_btn_clear = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cyc(3);
        rst = 1'b1;
        cyc(1);
    endtask

    // Monitor: outputs are only registered, so any pushed expectation is checked at once.
    initial begin
        exp_t e;
        forever begin
            wait (exp_q.size() != 0);
            e = exp_q.pop_front();
            total++;
            if (o_msec !== e.msec || o_sec !== e.sec || o_min !== e.min ||
                o_hour !== e.hour || o_running !== e.run) begin
                bad++;
                $display("FAIL %s: got %0d:%0d:%0d.%0d run=%0b, expected %0d:%0d:%0d.%0d run=%0b",
                         e.name, o_hour, o_min, o_sec, o_msec, o_running,
                         e.hour, e.min, e.sec, e.msec, e.run);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and idle
        cyc(1);
        expect_now("in_reset", 0, 0, 0, 0, 1'b0);
        cyc(2);
        rst = 1'b1;
        cyc(1);
        expect_now("after_release", 0, 0, 0, 0, 1'b0);
        cyc(50);
        expect_now("idle_50", 0, 0, 0, 0, 1'b0);

        // Run count and tick spacing
        pulse_run();
        expect_now("run_enter", 0, 0, 0, 0, 1'b1);
        cyc(9);
        expect_now("before_tick1", 0, 0, 0, 0, 1'b1);
        cyc(1);
        expect_now("tick1", 0, 0, 0, 1, 1'b1);
        cyc(980);
        expect_now("cyc990", 0, 0, 0, 99, 1'b1);
        cyc(9);
        expect_now("cyc999", 0, 0, 0, 99, 1'b1);
        cyc(1);
        expect_now("cyc1000", 0, 0, 1, 0, 1'b1);

        // Pause/resume keeps divider phase
        do_reset();
        pulse_run();
        cyc(24);
        pulse_run();
        expect_now("pause", 0, 0, 0, 2, 1'b0);
        cyc(100);
        expect_now("pause_hold", 0, 0, 0, 2, 1'b0);
        pulse_run();
        expect_now("resume", 0, 0, 0, 2, 1'b1);
        cyc(4);
        expect_now("resume_4", 0, 0, 0, 2, 1'b1);
        cyc(1);
        expect_now("resume_5", 0, 0, 0, 3, 1'b1);

        // Clear ignored while running
        pulse_clear();
        expect_now("clear_in_run", 0, 0, 0, 3, 1'b1);
        cyc(9);
        expect_now("clear_in_run_cont", 0, 0, 0, 4, 1'b1);

        // Clear while stopped, divider also zeroed
        pulse_run();
        expect_now("stop_before_clear", 0, 0, 0, 4, 1'b0);
        pulse_clear();
        cyc(1);
        expect_now("cleared", 0, 0, 0, 0, 1'b0);
        pulse_run();
        cyc(9);
        expect_now("post_clear_9", 0, 0, 0, 0, 1'b1);
        cyc(1);
        expect_now("post_clear_10", 0, 0, 0, 1, 1'b1);

        // Run and clear together in STOP: run wins
        pulse_run();
        expect_now("stop_again", 0, 0, 0, 1, 1'b0);
        pulse_both();
        expect_now("both_run_wins", 0, 0, 0, 1, 1'b1);
        cyc(2);
        expect_now("both_not_cleared", 0, 0, 0, 1, 1'b1);

        // Full rollover from a preloaded 23:59:59.98
        do_reset();
        force dut.msec_q = 7'd98;
        force dut.sec_q  = 6'd59;
        force dut.min_q  = 6'd59;
        force dut.hour_q = 5'd23;
        cyc(1);
        release dut.msec_q;
        release dut.sec_q;
        release dut.min_q;
        release dut.hour_q;
        expect_now("preload", 23, 59, 59, 98, 1'b0);
        pulse_run();
        cyc(10);
        expect_now("roll_99", 23, 59, 59, 99, 1'b1);
        cyc(9);
        expect_now("roll_hold", 23, 59, 59, 99, 1'b1);
        cyc(1);
        expect_now("rollover", 0, 0, 0, 0, 1'b1);

        // Asynchronous reset mid-run
        do_reset();
        pulse_run();
        cyc(3410);
        expect_now("at_3_41", 0, 0, 3, 41, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        expect_now("async_rst", 0, 0, 0, 0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        cyc(50);
        expect_now("post_rst_idle", 0, 0, 0, 0, 1'b0);
        pulse_run();
        cyc(10);
        expect_now("post_rst_run", 0, 0, 0, 1, 1'b1);

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
